// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control unit: main FSM, ALU decoder and immediate-format select.
// Optional bne support is compiled in with `define MULTICYCLE_CTRL_BNE_EN.
module multicycle_ctrl #(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       illegal
);

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 7;

    localparam logic [OP_W-1:0] OP_LW     = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW     = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_HALT     = 4'd10
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic       done;
    logic       ill;
    logic       take;
    logic [1:0] alu_op;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        state_d   = S_FETCH;
        pc_update = 1'b0;
        branch    = 1'b0;
        ir_write  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        done      = 1'b0;
        ill       = 1'b0;
        alu_op    = 2'b00;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_write  = 1'b1;
                pc_update = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECR;
                    OP_ITYPE:     state_d = S_EXECI;
                    OP_BRANCH:    state_d = S_BEQ;
                    default: begin
                        ill     = 1'b1;
                        state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
                done      = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                done      = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                done      = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
                done    = 1'b1;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

`ifdef MULTICYCLE_CTRL_BNE_EN
    assign take = (funct3 == 3'b001) ? ~zero : zero;
`else
    assign take = zero;
`endif

    // Strobes are suppressed for the whole reset cycle
    assign PCWrite    = ~rst & (pc_update | (branch & take));
    assign IRWrite    = ~rst & ir_write;
    assign MemWrite   = ~rst & mem_write;
    assign RegWrite   = ~rst & reg_write;
    assign instr_done = ~rst & done;
    assign illegal    = ~rst & ill;

    // Immediate format depends only on the opcode
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:     ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            default:   ImmSrc = 2'b00;
        endcase
    end

    // ALU decoder
    always_comb begin
        ALUControl = ALU_ADD;
        case (alu_op)
            2'b01: ALUControl = ALU_SUB;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = ({op[5], funct7b5} == 2'b11) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl; a second instance covers the halting build.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'b0000000;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;

    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic       h_PCWrite, h_AdrSrc, h_MemWrite, h_IRWrite, h_RegWrite, h_instr_done, h_illegal;
    logic [1:0] h_ResultSrc, h_ALUSrcA, h_ALUSrcB, h_ImmSrc;
    logic [2:0] h_ALUControl;

    logic [17:0] obs, obs_h;
    logic [17:0] q_exp[$];
    logic [17:0] q_hexp[$];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.ILLEGAL_HALT(1'b0)) u_dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .instr_done(instr_done), .illegal(illegal)
    );

    multicycle_ctrl #(.ILLEGAL_HALT(1'b1)) u_halt (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .PCWrite(h_PCWrite), .AdrSrc(h_AdrSrc), .MemWrite(h_MemWrite), .IRWrite(h_IRWrite),
        .ResultSrc(h_ResultSrc), .ALUSrcA(h_ALUSrcA), .ALUSrcB(h_ALUSrcB), .ALUControl(h_ALUControl),
        .ImmSrc(h_ImmSrc), .RegWrite(h_RegWrite), .instr_done(h_instr_done), .illegal(h_illegal)
    );

    assign obs   = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                    ALUControl, ImmSrc, RegWrite, instr_done, illegal};
    assign obs_h = {h_PCWrite, h_AdrSrc, h_MemWrite, h_IRWrite, h_ResultSrc, h_ALUSrcA, h_ALUSrcB,
                    h_ALUControl, h_ImmSrc, h_RegWrite, h_instr_done, h_illegal};

    function automatic logic [17:0] ev(input logic pcw, input logic adr, input logic mw, input logic irw,
                                       input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] alu, input logic [1:0] imm,
                                       input logic rw, input logic dn, input logic il);
        return {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, dn, il};
    endfunction

    // Expected output vector of each state, straight from the state table
    function automatic logic [17:0] st_vec(input int s, input logic [1:0] imm, input logic [2:0] alu,
                                           input logic pcw);
        case (s)
            0:       return ev(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, imm, 0, 0, 0);
            1:       return ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0, 0, 0);
            2:       return ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, imm, 0, 0, 0);
            3:       return ev(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0, 0, 0);
            4:       return ev(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, imm, 1, 1, 0);
            5:       return ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0, 1, 0);
            6:       return ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu,    imm, 0, 0, 0);
            7:       return ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu,    imm, 0, 0, 0);
            8:       return ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1, 1, 0);
            9:       return ev(pcw, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, imm, 0, 1, 0);
            default: return ev(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 0, 0, 0);
        endcase
    endfunction

    task automatic push(input logic [17:0] v);
        q_exp.push_back(v);
        q_hexp.push_back(v);
    endtask

    task automatic chk(input string tag);
        logic [17:0] e, eh;
        @(negedge clk);
        if (q_exp.size() == 0 || q_hexp.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e  = q_exp.pop_front();
            eh = q_hexp.pop_front();
            total++;
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s main obs=%b exp=%b", tag, obs, e);
            end
            total++;
            assert (obs_h === eh) else begin
                bad++;
                $error("FAIL %s halt obs=%b exp=%b", tag, obs_h, eh);
            end
        end
    endtask

    task automatic drain(input string tag);
        while (q_exp.size() > 0) chk(tag);
    endtask

    // Inputs change just after the active edge; outputs are checked on the falling edge
    task automatic start(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        zero     = z;
    endtask

    task automatic do_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                            input logic f7, input logic z, input logic [1:0] imm,
                            input logic [2:0] alu, input logic pcw,
                            input int s2, input int s3, input int s4);
        start(o, f3, f7, z);
        push(st_vec(0, imm, 3'b000, 1'b0));
        push(st_vec(1, imm, 3'b000, 1'b0));
        if (s2 >= 0) push(st_vec(s2, imm, alu, pcw));
        if (s3 >= 0) push(st_vec(s3, imm, alu, pcw));
        if (s4 >= 0) push(st_vec(s4, imm, alu, pcw));
        drain(tag);
    endtask

    logic [17:0] fetch_gated;
    logic [17:0] dec_ill;
    logic        bne_z1;
    logic        bne_z0;

    initial begin
        fetch_gated = ev(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0, 0);
        dec_ill     = ev(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b00, 0, 0, 1);
`ifdef MULTICYCLE_CTRL_BNE_EN
        bne_z1 = 1'b0;
        bne_z0 = 1'b1;
`else
        bne_z1 = 1'b1;
        bne_z0 = 1'b0;
`endif

        // Two reset cycles: FETCH selects visible, every strobe held low
        @(posedge clk);
        #1;
        push(fetch_gated);
        push(fetch_gated);
        drain("reset");

        do_instr("lw",    7'b0000011, 3'b010, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 2, 3, 4);
        do_instr("sw",    7'b0100011, 3'b010, 1'b0, 1'b0, 2'b01, 3'b000, 1'b0, 2, 5, -1);
        do_instr("sub",   7'b0110011, 3'b000, 1'b1, 1'b0, 2'b00, 3'b001, 1'b0, 6, 8, -1);
        do_instr("add",   7'b0110011, 3'b000, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 6, 8, -1);
        do_instr("and",   7'b0110011, 3'b111, 1'b0, 1'b0, 2'b00, 3'b010, 1'b0, 6, 8, -1);
        do_instr("or",    7'b0110011, 3'b110, 1'b0, 1'b0, 2'b00, 3'b011, 1'b0, 6, 8, -1);
        do_instr("slt",   7'b0110011, 3'b010, 1'b0, 1'b0, 2'b00, 3'b101, 1'b0, 6, 8, -1);
        do_instr("addi",  7'b0010011, 3'b000, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 7, 8, -1);
        do_instr("slti",  7'b0010011, 3'b010, 1'b0, 1'b0, 2'b00, 3'b101, 1'b0, 7, 8, -1);
        do_instr("ori",   7'b0010011, 3'b110, 1'b0, 1'b0, 2'b00, 3'b011, 1'b0, 7, 8, -1);
        do_instr("xf3",   7'b0010011, 3'b100, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 7, 8, -1);
        do_instr("beq_t", 7'b1100011, 3'b000, 1'b0, 1'b1, 2'b10, 3'b001, 1'b1, 9, -1, -1);
        do_instr("beq_n", 7'b1100011, 3'b000, 1'b0, 1'b0, 2'b10, 3'b001, 1'b0, 9, -1, -1);
        do_instr("bne_1", 7'b1100011, 3'b001, 1'b0, 1'b1, 2'b10, 3'b001, bne_z1, 9, -1, -1);
        do_instr("bne_0", 7'b1100011, 3'b001, 1'b0, 1'b0, 2'b10, 3'b001, bne_z0, 9, -1, -1);

        // Reset lands on MEMREAD: the load is abandoned, no write-back
        start(7'b0000011, 3'b010, 1'b0, 1'b0);
        push(st_vec(0, 2'b00, 3'b000, 1'b0));
        push(st_vec(1, 2'b00, 3'b000, 1'b0));
        push(st_vec(2, 2'b00, 3'b000, 1'b0));
        drain("lw_pre");
        @(posedge clk);
        #1;
        rst = 1'b1;
        push(st_vec(3, 2'b00, 3'b000, 1'b0));
        push(fetch_gated);
        drain("rst_mid");
        start(7'b0000011, 3'b010, 1'b0, 1'b0);
        for (int s = 0; s <= 4; s++) push(st_vec(s, 2'b00, 3'b000, 1'b0));
        drain("lw_post");

        // Illegal opcode: main instance loops FETCH/DECODE, halting instance parks in HALT
        start(7'b1111111, 3'b000, 1'b0, 1'b0);
        push(st_vec(0, 2'b00, 3'b000, 1'b0));
        push(dec_ill);
        for (int i = 0; i < 10; i++) begin
            q_exp.push_back((i % 2 == 0) ? st_vec(0, 2'b00, 3'b000, 1'b0) : dec_ill);
            q_hexp.push_back(18'd0);
        end
        drain("illegal");
        @(posedge clk);
        #1;
        rst = 1'b1;
        q_exp.push_back(fetch_gated);
        q_hexp.push_back(18'd0);
        drain("ill_rst");
        start(7'b1111111, 3'b000, 1'b0, 1'b0);
        push(st_vec(0, 2'b00, 3'b000, 1'b0));
        drain("halt_exit");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
